// File: rtl/dds_sweep_ctrl.sv
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Frequency-sweep scheduler driving the DDS Fword/Pword inputs.
//               Optional triangle sweep enabled by macro DDS_SWEEP_TRI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_fstart,
  input  logic [31:0]        cfg_fstop,
  input  logic [31:0]        cfg_fstep,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [10:0]        cfg_pword,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        Fword,
  output logic [10:0]        Pword,
  output logic               busy,
  output logic               done
);

  localparam logic [DWELL_W-1:0] C_DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fstart;
  logic [31:0]        r_fstop;
  logic [31:0]        r_fstep;
  logic [DWELL_W-1:0] r_dwell;
  logic [10:0]        r_pword;
  logic               r_repeat;
  logic [DWELL_W-1:0] r_cnt;
  logic [31:0]        r_fword;
  logic [10:0]        r_pword_out;
  logic               r_done;

  logic [DWELL_W-1:0] w_dwell_load;
  logic [32:0]        w_sum;
  logic [31:0]        w_up_next;
  logic               w_no_span;
  logic               w_end;
  logic [31:0]        w_next;

`ifdef DDS_SWEEP_TRI_EN
  logic               r_dir_down;
  logic               w_flip;
  logic [32:0]        w_diff;
  logic [31:0]        w_dn_next;
`endif

  // A dwell of zero behaves as a dwell of one; the counter runs D-1 .. 0.
  assign w_dwell_load = (r_dwell == '0) ? '0 : (r_dwell - C_DWELL_ONE);

  always_comb begin
    w_sum     = {1'b0, r_fword} + {1'b0, r_fstep};
    w_up_next = (w_sum > {1'b0, r_fstop}) ? r_fstop : w_sum[31:0];
    w_no_span = (r_fstart >= r_fstop);
`ifdef DDS_SWEEP_TRI_EN
    // Borrow out of the 33-bit difference means we went below zero.
    w_diff    = {1'b0, r_fword} - {1'b0, r_fstep};
    w_dn_next = (w_diff[32] || (w_diff[31:0] < r_fstart)) ? r_fstart : w_diff[31:0];
    w_flip    = 1'b0;
    w_end     = 1'b0;
    w_next    = w_up_next;
    if (r_dir_down) begin
      w_end  = (r_fword == r_fstart);
      w_next = w_dn_next;
    end else if (w_no_span) begin
      w_end  = 1'b1;
    end else if (r_fword == r_fstop) begin
      // Turn around without dwelling on fstop a second time.
      w_flip = 1'b1;
      w_next = w_dn_next;
    end
`else
    w_end     = w_no_span || (r_fword == r_fstop);
    w_next    = w_up_next;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_fstart    <= '0;
      r_fstop     <= '0;
      r_fstep     <= '0;
      r_dwell     <= '0;
      r_pword     <= '0;
      r_repeat    <= 1'b0;
      r_cnt       <= '0;
      r_fword     <= '0;
      r_pword_out <= '0;
      r_done      <= 1'b0;
`ifdef DDS_SWEEP_TRI_EN
      r_dir_down  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (cfg_valid && (r_state == ST_IDLE)) begin
        r_fstart <= cfg_fstart;
        r_fstop  <= cfg_fstop;
        r_fstep  <= cfg_fstep;
        r_dwell  <= cfg_dwell;
        r_pword  <= cfg_pword;
        r_repeat <= cfg_repeat;
      end
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state     <= ST_RUN;
            r_fword     <= r_fstart;
            r_pword_out <= r_pword;
            r_cnt       <= w_dwell_load;
`ifdef DDS_SWEEP_TRI_EN
            r_dir_down  <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == '0) begin
            r_cnt <= w_dwell_load;
            if (w_end) begin
              if (r_repeat) begin
                r_fword    <= r_fstart;
`ifdef DDS_SWEEP_TRI_EN
                r_dir_down <= 1'b0;
`endif
              end else begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_fword <= w_next;
`ifdef DDS_SWEEP_TRI_EN
              if (w_flip) r_dir_down <= 1'b1;
`endif
            end
          end else begin
            r_cnt <= r_cnt - C_DWELL_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign Fword     = r_fword;
  assign Pword     = r_pword_out;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
// ============================================================================
// Module      : tb_dds_sweep_ctrl
// Description : Self-checking bench for dds_sweep_ctrl (honours DDS_SWEEP_TRI_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_fstart = '0;
  logic [31:0] cfg_fstop = '0;
  logic [31:0] cfg_fstep = '0;
  logic [15:0] cfg_dwell = '0;
  logic [10:0] cfg_pword = '0;
  logic        cfg_repeat = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] Fword;
  logic [10:0] Pword;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Shadow-config model and the expected word sequence of one sweep.
  longint      m_fs, m_fe, m_st;
  int          m_dw;
  logic [10:0] m_pw;
  logic [31:0] m_last;
  logic [31:0] exp_q[$];

  dds_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fstart(cfg_fstart), .cfg_fstop(cfg_fstop), .cfg_fstep(cfg_fstep),
    .cfg_dwell(cfg_dwell), .cfg_pword(cfg_pword), .cfg_repeat(cfg_repeat),
    .start(start), .abort(abort),
    .Fword(Fword), .Pword(Pword), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word list of one sweep from the arithmetic rules (fstep must be >0 if fs<fe).
  function automatic void build_sweep();
    longint f;
    exp_q.delete();
    f = m_fs;
    exp_q.push_back(f[31:0]);
    if (m_fs < m_fe) begin
      while (f != m_fe) begin
        f = (f + m_st > m_fe) ? m_fe : f + m_st;
        exp_q.push_back(f[31:0]);
      end
`ifdef DDS_SWEEP_TRI_EN
      while (f != m_fs) begin
        f = (f - m_st < m_fs) ? m_fs : f - m_st;
        exp_q.push_back(f[31:0]);
      end
`endif
    end
  endfunction

  task automatic configure(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                           input logic [15:0] dw, input logic [10:0] pw, input logic rep);
    cfg_valid = 1'b1;  cfg_fstart = fs; cfg_fstop = fe; cfg_fstep = st;
    cfg_dwell = dw;    cfg_pword = pw;  cfg_repeat = rep;
    tick();
    cfg_valid = 1'b0;
    m_fs = longint'(fs); m_fe = longint'(fe); m_st = longint'(st);
    m_dw = int'(dw); m_pw = pw;
  endtask

  // Starts a sweep from the modelled shadow config. rep: run until abort_at.
  // poke: offer start and a foreign config mid-sweep, both must be ignored.
  task automatic run_sweep(input string tag, input bit rep, input bit poke, input int abort_at);
    int d, n, lim;
    chk({tag, "_ready_idle"}, 64'(cfg_ready), 64'd1);
    build_sweep();
    d = (m_dw == 0) ? 1 : m_dw;
    n = exp_q.size();
    lim = rep ? abort_at + 1 : n * d;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_pword"}, 64'(Pword), 64'(m_pw));
    for (int t = 0; t < lim; t++) begin
      chk({tag, "_fword"}, 64'(Fword), 64'(exp_q[(t / d) % n]));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_done_low"}, 64'(done), 64'd0);
      chk({tag, "_ready_run"}, 64'(cfg_ready), 64'd0);
      if (poke && t == 1) begin
        start = 1'b1; cfg_valid = 1'b1; cfg_fstart = ~m_fs[31:0];
      end
      if (poke && t == 2) begin
        start = 1'b0; cfg_valid = 1'b0;
      end
      if (rep && t == abort_at) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    m_last = rep ? exp_q[(abort_at / d) % n] : exp_q[n - 1];
    chk({tag, "_end_busy"}, 64'(busy), 64'd0);
    chk({tag, "_end_done"}, 64'(done), rep ? 64'd0 : 64'd1);
    chk({tag, "_end_ready"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_end_fword"}, 64'(Fword), 64'(m_last));
    tick();
    chk({tag, "_post_done"}, 64'(done), 64'd0);
    chk({tag, "_post_fword"}, 64'(Fword), 64'(m_last));
    chk({tag, "_post_pword"}, 64'(Pword), 64'(m_pw));
  endtask

  initial begin
    logic [31:0] fs, span;
    reset_n = 1'b0;
    m_fs = 0; m_fe = 0; m_st = 0; m_dw = 0; m_pw = '0;
    #1;
    chk("rst_fword", 64'(Fword), 64'd0);
    chk("rst_pword", 64'(Pword), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    #11 reset_n = 1'b1;
    tick();

    configure(32'd100, 32'd400, 32'd100, 16'd3, 11'h155, 1'b0);
    run_sweep("basic", 1'b0, 1'b1, 0);
    run_sweep("reuse_shadow", 1'b0, 1'b0, 0);

    configure(32'd0, 32'd250, 32'd100, 16'd1, 11'h7FF, 1'b0);
    run_sweep("saturate", 1'b0, 1'b0, 0);

    configure(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd2, 11'd3, 1'b0);
    run_sweep("nowrap", 1'b0, 1'b0, 0);

    configure(32'd50, 32'd50, 32'd0, 16'd0, 11'd9, 1'b0);
    run_sweep("zero_step_dwell0", 1'b0, 1'b0, 0);

    configure(32'd10, 32'd30, 32'd10, 16'd2, 11'd1, 1'b1);
    run_sweep("repeat_abort", 1'b1, 1'b0, 9);

    // start and abort together in IDLE must leave the block idle.
    configure(32'd77, 32'd99, 32'd1, 16'd1, 11'd2, 1'b0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_ready", 64'(cfg_ready), 64'd1);
    chk("start_abort_fword", 64'(Fword), 64'(m_last));
    tick();
    chk("start_abort_busy2", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      fs   = $urandom_range(0, 32'hFFF0_0000);
      span = $urandom_range(0, 3000);
      configure(fs, (i % 3 == 2) ? fs - span : fs + span, $urandom_range(50, 1000),
                16'($urandom_range(0, 4)), 11'($urandom), 1'b0);
      run_sweep("random", 1'b0, 1'b0, 0);
    end

    // Reset mid-sweep clears outputs and shadow config.
    configure(32'd5000, 32'd9000, 32'd100, 16'd3, 11'd44, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_fword", 64'(Fword), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(cfg_ready), 64'd1);
    #3 reset_n = 1'b1;
    m_fs = 0; m_fe = 0; m_st = 0; m_dw = 0; m_pw = '0;
    tick();
    run_sweep("after_reset", 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
